// File: rtl/pla_bist_driver.sv
// BIST driver for 16-input single-output PLA blocks: LFSR pattern source,
// serial MISR response compactor and ones counter behind a start/done handshake.
module pla_bist_driver #(
  parameter logic [15:0] LFSR_POLY = 16'h002D,
  parameter logic [15:0] SIG_POLY  = 16'h002D,
  parameter int unsigned SETTLE    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] seed,
  input  logic [15:0] count,
  output logic [15:0] x_out,
  output logic        x_valid,
  input  logic        y_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [15:0] ones_count
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [15:0] r_remain;
  logic [3:0]  r_hold;
  logic [15:0] r_sig;
  logic [15:0] r_ones;
  logic        r_busy;
  logic        r_x_valid;
  logic        r_done;

  logic [15:0] w_lfsr_next;
  logic [15:0] w_sig_next;
  logic [15:0] w_seed_safe;
  logic        w_last_hold;

  // Galois shift with feedback gated by the outgoing MSB; bit 0 of the MISR
  // additionally absorbs the sampled response.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign w_lfsr_next[gi] = r_lfsr[15] & LFSR_POLY[gi];
        assign w_sig_next[gi]  = y_in ^ (r_sig[15] & SIG_POLY[gi]);
      end else begin : g_upper
        assign w_lfsr_next[gi] = r_lfsr[gi-1] ^ (r_lfsr[15] & LFSR_POLY[gi]);
        assign w_sig_next[gi]  = r_sig[gi-1] ^ (r_sig[15] & SIG_POLY[gi]);
      end
    end
  endgenerate

  // An all-zero LFSR state never leaves zero, so a zero seed is substituted.
  assign w_seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;
  assign w_last_hold = (r_hold == SETTLE_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= 16'h0000;
      r_remain  <= 16'h0000;
      r_hold    <= 4'd0;
      r_sig     <= 16'hFFFF;
      r_ones    <= 16'h0000;
      r_busy    <= 1'b0;
      r_x_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sig  <= 16'hFFFF;
            r_ones <= 16'h0000;
            if (count != 16'h0000) begin
              r_remain  <= count;
              r_lfsr    <= w_seed_safe;
              r_hold    <= 4'd0;
              r_busy    <= 1'b1;
              r_x_valid <= 1'b1;
              r_state   <= S_APPLY;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_APPLY: begin
          // Abort takes precedence over a coincident sample edge.
          if (abort) begin
            r_busy    <= 1'b0;
            r_x_valid <= 1'b0;
            r_hold    <= 4'd0;
            r_state   <= S_IDLE;
          end else if (w_last_hold) begin
            r_sig    <= w_sig_next;
            r_ones   <= r_ones + {15'b0, y_in};
            r_lfsr   <= w_lfsr_next;
            r_remain <= r_remain - 16'd1;
            r_hold   <= 4'd0;
            if (r_remain == 16'd1) begin
              r_busy    <= 1'b0;
              r_x_valid <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy    <= 1'b0;
          r_x_valid <= 1'b0;
          r_done    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign x_out      = r_lfsr;
  assign x_valid    = r_x_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign signature  = r_sig;
  assign ones_count = r_ones;

endmodule

// File: tb/tb_pla_bist_driver.sv
// Self-checking bench for pla_bist_driver: two instances (SETTLE=0 and SETTLE=3)
// driven by behavioural PLA stand-ins and checked against a run-level model.
module tb_pla_bist_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, abort0 = 1'b0;
  logic [15:0] seed0 = '0, count0 = '0;
  logic [15:0] x0, sig0, ones0;
  logic        xv0, busy0, done0, y0;

  logic        start3 = 1'b0, abort3 = 1'b0;
  logic [15:0] seed3 = '0, count3 = '0;
  logic [15:0] x3, sig3, ones3;
  logic        xv3, busy3, done3, y3;

  int          mode0 = 0, mode3 = 0;
  logic [15:0] mask0 = '0, mask3 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Stand-in for the evaluated block: 0, 1, full parity, or masked parity.
  function automatic logic yfun(input int mode, input logic [15:0] mask, input logic [15:0] x);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return ^x;
      default: return ^(x & mask);
    endcase
  endfunction

  assign y0 = yfun(mode0, mask0, x0);
  assign y3 = yfun(mode3, mask3, x3);

  pla_bist_driver #(.LFSR_POLY(16'h002D), .SIG_POLY(16'h002D), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .seed(seed0), .count(count0),
    .x_out(x0), .x_valid(xv0), .y_in(y0), .busy(busy0), .done(done0),
    .signature(sig0), .ones_count(ones0)
  );

  pla_bist_driver #(.LFSR_POLY(16'h002D), .SIG_POLY(16'h002D), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .seed(seed3), .count(count3),
    .x_out(x3), .x_valid(xv3), .y_in(y3), .busy(busy3), .done(done3),
    .signature(sig3), .ones_count(ones3)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], 1'b0} ^ (x[15] ? 16'h002D : 16'h0000);
  endfunction

  // Whole-run reference: the vector stream, the response per vector, and the
  // resulting signature/ones after n vectors.
  function automatic void model(input logic [15:0] seed, input int n, input int mode,
                                input logic [15:0] mask, output logic [15:0] sig, output int ones);
    logic [15:0] x;
    logic y;
    x = (seed == 16'h0000) ? 16'h0001 : seed;
    sig = 16'hFFFF;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      y = yfun(mode, mask, x);
      sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h002D : 16'h0000) ^ {15'b0, y};
      ones += int'(y);
      x = lfsr_step(x);
    end
  endfunction

  // Pulses start for one cycle; returns at the negedge inside cycle T+1.
  task automatic kick(input bit d3, input logic [15:0] seed, input logic [15:0] cnt, input bit immediate);
    if (!immediate) @(negedge clk);
    if (d3) begin seed3 = seed; count3 = cnt; start3 = 1'b1; end
    else    begin seed0 = seed; count0 = cnt; start0 = 1'b1; end
    @(negedge clk);
    start0 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic run_and_check(input bit d3, input logic [15:0] seed, input int cnt,
                               input bit immediate, input string name);
    logic [15:0] esig;
    int eones, s, cyc, limit;
    s = d3 ? 3 : 0;
    model(seed, cnt, d3 ? mode3 : mode0, d3 ? mask3 : mask0, esig, eones);
    kick(d3, seed, 16'(cnt), immediate);
    cyc = 1;
    limit = cnt * (s + 1) + 20;
    while (!(d3 ? done3 : done0) && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != 1 + cnt * (s + 1)) begin
      n_fail++;
      $display("FAIL %s done_cycle: got T+%0d expected T+%0d", name, cyc, 1 + cnt * (s + 1));
    end
    n_checks++;
    if ((d3 ? sig3 : sig0) !== esig) begin
      n_fail++;
      $display("FAIL %s signature: got %h expected %h", name, d3 ? sig3 : sig0, esig);
    end
    n_checks++;
    if ((d3 ? ones3 : ones0) !== 16'(eones)) begin
      n_fail++;
      $display("FAIL %s ones_count: got %0d expected %0d", name, d3 ? ones3 : ones0, eones);
    end
    $display("run %s: seed=%h count=%0d settle=%0d sig=%h ones=%0d", name, seed, cnt, s,
             d3 ? sig3 : sig0, d3 ? ones3 : ones0);
  endtask

  task automatic test_reset();
    #12;
    n_checks += 7;
    if (x0 !== 16'h0000)   begin n_fail++; $display("FAIL reset x_out: got %h expected 0000", x0); end
    if (xv0 !== 1'b0)      begin n_fail++; $display("FAIL reset x_valid: got %b expected 0", xv0); end
    if (busy0 !== 1'b0)    begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy0); end
    if (done0 !== 1'b0)    begin n_fail++; $display("FAIL reset done: got %b expected 0", done0); end
    if (sig0 !== 16'hFFFF) begin n_fail++; $display("FAIL reset signature: got %h expected ffff", sig0); end
    if (ones0 !== 16'h0)   begin n_fail++; $display("FAIL reset ones_count: got %h expected 0000", ones0); end
    if (busy3 !== 1'b0)    begin n_fail++; $display("FAIL reset busy3: got %b expected 0", busy3); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_pattern();
    logic [15:0] exp_x;
    mode0 = 0;
    kick(1'b0, 16'h0001, 16'd17, 1'b0);
    for (int k = 0; k < 17; k++) begin
      exp_x = (k < 16) ? (16'h0001 << k) : 16'h002D;
      n_checks += 2;
      if (x0 !== exp_x) begin n_fail++; $display("FAIL pattern x_out[%0d]: got %h expected %h", k, x0, exp_x); end
      if (xv0 !== 1'b1) begin n_fail++; $display("FAIL pattern x_valid[%0d]: got %b expected 1", k, xv0); end
      @(negedge clk);
    end
    n_checks += 3;
    if (done0 !== 1'b1)  begin n_fail++; $display("FAIL pattern done at T+18: got %b expected 1", done0); end
    if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL pattern busy at done: got %b expected 0", busy0); end
    if (ones0 !== 16'd0) begin n_fail++; $display("FAIL pattern ones_count: got %0d expected 0", ones0); end
    $display("run pattern: seed=0001 count=17 sig=%h ones=%0d", sig0, ones0);
  endtask

  task automatic test_single();
    mode0 = 0;
    kick(1'b0, 16'($urandom), 16'd1, 1'b0);
    @(negedge clk);
    n_checks += 3;
    if (done0 !== 1'b1)      begin n_fail++; $display("FAIL single0 done: got %b expected 1", done0); end
    if (sig0 !== 16'hFFD3)   begin n_fail++; $display("FAIL single0 signature: got %h expected ffd3", sig0); end
    if (ones0 !== 16'd0)     begin n_fail++; $display("FAIL single0 ones_count: got %0d expected 0", ones0); end
    $display("run single y=0: sig=%h ones=%0d", sig0, ones0);
    mode0 = 1;
    kick(1'b0, 16'($urandom), 16'd1, 1'b0);
    @(negedge clk);
    n_checks += 2;
    if (sig0 !== 16'hFFD2)   begin n_fail++; $display("FAIL single1 signature: got %h expected ffd2", sig0); end
    if (ones0 !== 16'd1)     begin n_fail++; $display("FAIL single1 ones_count: got %0d expected 1", ones0); end
    $display("run single y=1: sig=%h ones=%0d", sig0, ones0);
  endtask

  task automatic test_zero();
    mode0 = 1;
    kick(1'b0, 16'h0000, 16'd1, 1'b0);
    n_checks += 2;
    if (x0 !== 16'h0001) begin n_fail++; $display("FAIL zero_seed x_out: got %h expected 0001", x0); end
    if (xv0 !== 1'b1)    begin n_fail++; $display("FAIL zero_seed x_valid: got %b expected 1", xv0); end
    @(negedge clk);
    kick(1'b0, 16'($urandom), 16'd0, 1'b0);
    n_checks += 5;
    if (done0 !== 1'b1)    begin n_fail++; $display("FAIL zero_count done at T+1: got %b expected 1", done0); end
    if (xv0 !== 1'b0)      begin n_fail++; $display("FAIL zero_count x_valid: got %b expected 0", xv0); end
    if (busy0 !== 1'b0)    begin n_fail++; $display("FAIL zero_count busy: got %b expected 0", busy0); end
    if (sig0 !== 16'hFFFF) begin n_fail++; $display("FAIL zero_count signature: got %h expected ffff", sig0); end
    if (ones0 !== 16'd0)   begin n_fail++; $display("FAIL zero_count ones_count: got %0d expected 0", ones0); end
    @(negedge clk);
    n_checks += 2;
    if (xv0 !== 1'b0)   begin n_fail++; $display("FAIL zero_count x_valid after: got %b expected 0", xv0); end
    if (done0 !== 1'b0) begin n_fail++; $display("FAIL zero_count done width: got %b expected 0", done0); end
    $display("run zero: seed=0 and count=0 cases done");
  endtask

  task automatic test_settle_abort();
    logic [15:0] seed, exp_x, esig;
    int eones;
    bit seen;
    mode3 = 1;
    seed = 16'($urandom_range(1, 65535));
    exp_x = seed;
    kick(1'b1, seed, 16'd4, 1'b0);
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 4; h++) begin
        n_checks += 2;
        if (x3 !== exp_x) begin n_fail++; $display("FAIL settle x_out v%0d h%0d: got %h expected %h", v, h, x3, exp_x); end
        if (busy3 !== 1'b1) begin n_fail++; $display("FAIL settle busy v%0d h%0d: got %b expected 1", v, h, busy3); end
        if (v == 1 && h == 0) begin seed3 = 16'hBEEF; count3 = 16'd7; start3 = 1'b1; end
        else start3 = 1'b0;
        @(negedge clk);
      end
      exp_x = lfsr_step(exp_x);
    end
    n_checks += 2;
    if (done3 !== 1'b1)  begin n_fail++; $display("FAIL settle done at T+17: got %b expected 1", done3); end
    if (ones3 !== 16'd4) begin n_fail++; $display("FAIL settle ones_count: got %0d expected 4", ones3); end
    $display("run settle: seed=%h count=4 sig=%h ones=%0d", seed, sig3, ones3);

    kick(1'b1, seed, 16'd10, 1'b0);
    repeat (9) @(negedge clk);
    abort3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0;
    model(seed, 2, 1, 16'h0, esig, eones);
    n_checks += 4;
    if (busy3 !== 1'b0)       begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy3); end
    if (xv3 !== 1'b0)         begin n_fail++; $display("FAIL abort x_valid: got %b expected 0", xv3); end
    if (ones3 !== 16'(eones)) begin n_fail++; $display("FAIL abort ones_count: got %0d expected %0d", ones3, eones); end
    if (sig3 !== esig)        begin n_fail++; $display("FAIL abort signature: got %h expected %h", sig3, esig); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done3) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL abort done pulsed: got 1 expected 0"); end
    $display("run abort@10: ones=%0d sig=%h", ones3, sig3);

    kick(1'b1, seed, 16'd10, 1'b0);
    repeat (3) @(negedge clk);
    abort3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0;
    n_checks += 2;
    if (ones3 !== 16'd0)   begin n_fail++; $display("FAIL abort_on_sample ones_count: got %0d expected 0", ones3); end
    if (sig3 !== 16'hFFFF) begin n_fail++; $display("FAIL abort_on_sample signature: got %h expected ffff", sig3); end
    $display("run abort@sample: ones=%0d sig=%h", ones3, sig3);

    @(negedge clk);
    abort3 = 1'b1;
    kick(1'b1, seed, 16'd1, 1'b1);
    abort3 = 1'b0;
    n_checks++;
    if (busy3 !== 1'b1) begin n_fail++; $display("FAIL abort_in_idle busy: got %b expected 1", busy3); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (done3 !== 1'b1) begin n_fail++; $display("FAIL abort_in_idle done: got %b expected 1", done3); end
    $display("run abort-in-idle: done=%b", done3);
  endtask

  task automatic test_reset_mid();
    logic [15:0] seed;
    seed = 16'($urandom);
    mode0 = 2;
    kick(1'b0, seed, 16'd50, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (x0 !== 16'h0000)   begin n_fail++; $display("FAIL midreset x_out: got %h expected 0000", x0); end
    if (xv0 !== 1'b0)      begin n_fail++; $display("FAIL midreset x_valid: got %b expected 0", xv0); end
    if (busy0 !== 1'b0)    begin n_fail++; $display("FAIL midreset busy: got %b expected 0", busy0); end
    if (done0 !== 1'b0)    begin n_fail++; $display("FAIL midreset done: got %b expected 0", done0); end
    if (sig0 !== 16'hFFFF) begin n_fail++; $display("FAIL midreset signature: got %h expected ffff", sig0); end
    if (ones0 !== 16'd0)   begin n_fail++; $display("FAIL midreset ones_count: got %0d expected 0", ones0); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("mid-run reset applied and released");
    run_and_check(1'b0, seed, 50, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [15:0] seed;
    mode0 = 3;
    mask0 = 16'($urandom);
    seed = 16'($urandom);
    run_and_check(1'b0, seed, 3, 1'b0, "b2b_first");
    seed0 = 16'h1357; count0 = 16'd5; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n_checks++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL b2b start_in_done ignored: busy=%b expected 0", busy0); end
    run_and_check(1'b0, seed ^ 16'h00FF, 5, 1'b1, "b2b_restart");
  endtask

  task automatic test_golden();
    mode0 = 2;
    run_and_check(1'b0, 16'($urandom), 1000, 1'b0, "golden_parity");
    for (int i = 0; i < 3; i++) begin
      mode0 = 3;
      mask0 = 16'($urandom);
      run_and_check(1'b0, 16'($urandom), int'($urandom_range(1, 200)), 1'b0, "golden_masked");
    end
    mode3 = 3;
    mask3 = 16'($urandom);
    run_and_check(1'b1, 16'($urandom), 60, 1'b0, "golden_settle3");
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_single();
    test_zero();
    test_settle_abort();
    test_reset_mid();
    test_back_to_back();
    test_golden();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
